// File: rtl/fetch_align_buffer.sv
// rtl/fetch_align_buffer.sv - halfword-granular fetch buffer delivering aligned RV32/RVC instructions
module fetch_align_buffer #(
  parameter int DEPTH_HW = 8,
  parameter int PC_W     = 32,
  parameter int CNT_W    = $clog2(DEPTH_HW) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [31:0]      fetch_data,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst_out,
  output logic [PC_W-1:0]  inst_pc,
  output logic             inst_is_c,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH_HW);

  logic [15:0]      mem [DEPTH_HW];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PC_W-1:0]  head_pc;
  logic [15:0]      hw0;
  logic [15:0]      hw1;
  logic             push;
  logic             pop;
  logic             push_two;
  logic             pop_two;
  logic [CNT_W-1:0] push_n;
  logic [CNT_W-1:0] pop_n;
  logic [CNT_W-1:0] count_after_pop;

  always_comb begin
    hw0        = mem[rd_ptr];
    hw1        = mem[rd_ptr + PTR_W'(1)];
    inst_is_c  = (count != '0) && (hw0[1:0] != 2'b11);
    // A 32-bit instruction is only presented once both halves are held.
    inst_valid = inst_is_c || (count >= CNT_W'(2));
    inst_out   = 32'h0;
    inst_pc    = '0;
    if (inst_valid) begin
      inst_out = inst_is_c ? {16'h0, hw0} : {hw1, hw0};
      inst_pc  = head_pc;
    end
    fetch_ready     = (count <= CNT_W'(DEPTH_HW - 2));
    push            = fetch_valid && fetch_ready;
    pop             = inst_valid && inst_ready;
    push_two        = !fetch_pc[1];
    pop_two         = !inst_is_c;
    push_n          = push ? (push_two ? CNT_W'(2) : CNT_W'(1)) : '0;
    pop_n           = pop  ? (pop_two  ? CNT_W'(2) : CNT_W'(1)) : '0;
    count_after_pop = count - pop_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      head_pc <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      head_pc <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      count  <= count_after_pop + push_n;
      // An empty (or just-drained) buffer takes its head PC from the incoming fetch.
      if (push && (count_after_pop == '0)) begin
        head_pc <= fetch_pc;
      end else if (pop) begin
        head_pc <= head_pc + (pop_two ? PC_W'(4) : PC_W'(2));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      if (push_two) begin
        mem[wr_ptr]              <= fetch_data[15:0];
        mem[wr_ptr + PTR_W'(1)]  <= fetch_data[31:16];
      end else begin
        mem[wr_ptr] <= fetch_data[31:16];
      end
    end
  end

endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
- Parametrised halfword-granular instruction buffer between the fetch interface and decode for the RV32 C-extension pipeline.
- Accepts 32-bit fetch words, including fetches that start at a halfword-misaligned PC after a jump.
- Delivers one complete instruction per handshake: 16-bit compressed, or 32-bit assembled across fetch-word boundaries, with its PC.
- Supports flush on redirect and back-to-back push/pop.

Parameters:
DEPTH_HW, 8, buffer capacity in 16-bit halfwords; power of two, minimum 4
PC_W, 32, width of PC fields
CNT_W, $clog2(DEPTH_HW)+1, occupancy counter width (derived)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of all buffered content (redirect/branch)
fetch_valid  in  1  fetch word and PC present
fetch_ready  out  1  buffer can accept a full fetch word this cycle
fetch_data  in  32  fetch word; [15:0] is the lower-address halfword
fetch_pc  in  PC_W  PC of the word; bit1 set = misaligned start, bit0 always 0
inst_valid  out  1  a complete instruction is at the head
inst_ready  in  1  decode accepts the head instruction
inst_out  out  32  instruction; compressed instructions are zero-extended to {16'h0, hw}
inst_pc  out  PC_W  PC of inst_out
inst_is_c  out  1  head instruction is compressed (hw[1:0] != 2'b11)
count  out  CNT_W  current occupancy in halfwords

Behaviour:
- Storage: circular array of DEPTH_HW halfwords with wr_ptr, rd_ptr and count. head_pc register holds the PC of the halfword at rd_ptr.
- Reset (reset low, async):
  - wr_ptr, rd_ptr and count = 0; head_pc = 0.
  - Outputs: inst_valid=0, inst_out=0, inst_pc=0, inst_is_c=0, fetch_ready=1.
  - Reset asserted mid-operation discards all content immediately.
- Push: fires when fetch_valid & fetch_ready.
  - fetch_pc[1]=0: writes fetch_data[15:0] then fetch_data[31:16] (2 halfwords).
  - fetch_pc[1]=1: writes only fetch_data[31:16] (1 halfword).
- fetch_ready = (DEPTH_HW - count) >= 2. This is combinational from registered count only; same-cycle pops are not credited.
- Head decode (combinational from registered state):
  - hw0 = entry[rd_ptr], hw1 = entry[rd_ptr+1] (mod DEPTH_HW).
  - inst_is_c = (count>=1) & (hw0[1:0] != 2'b11).
  - inst_valid = inst_is_c ? count>=1 : count>=2.
  - inst_out = inst_is_c ? {16'h0,hw0} : {hw1,hw0}. inst_out is 0 when inst_valid=0.
  - inst_pc = head_pc, or 0 when inst_valid=0.
- Pop: fires when inst_valid & inst_ready.
  - Advances rd_ptr by 1 (compressed) or 2.
  - head_pc += 2 or 4.
  - A 32-bit instruction whose upper half is not yet present holds inst_valid=0; it never pops partially.
- Simultaneous push and pop in one cycle: count_next = count + pushed - popped.
- head_pc load: if count_next-before-push is 0, i.e. the buffer is empty or becomes empty by this pop, and a push fires, head_pc <= fetch_pc. Otherwise head_pc follows the pop increment.
- Sequential-stream rule: between flushes, each fetch_pc equals the previous fetch's word address + 4. The block does not check this.
- Flush: synchronous.
  - Next cycle: count=0, pointers=0, head_pc=0.
  - Overrides any push or pop in the same cycle; inst_valid is still evaluated from current state that cycle.
- Pointer wrap: modulo DEPTH_HW. A 32-bit instruction straddling the wrap point (rd_ptr=DEPTH_HW-1) assembles from entry[DEPTH_HW-1] and entry[0].
- Latency: a pushed halfword is visible at the head the cycle after the push; no bypass.
- Full: count=DEPTH_HW-1 or DEPTH_HW forces fetch_ready=0, including for a misaligned 1-halfword push.
- count never exceeds DEPTH_HW; overflow and underflow are impossible by construction.

Test Plan:
- Reset then aligned push {32'h0000_4501 hi, lo=16'h4501}? Simplified case: fetch_data=32'h00A0_0513 (addi, 32-bit), pc=0x100 -> next cycle inst_valid=1, inst_out=32'h00A00513, inst_pc=0x100, inst_is_c=0.
- Push fetch_data=32'h4585_4501 (two c.li), pc=0x200, inst_ready=1 -> two cycles of inst_is_c=1: inst_out=32'h00004501 @0x200, then 32'h00004585 @0x202; count ends at 0.
- Straddle: push 32'h0513_4501 @0x300, then 32'h1234_00A0 @0x304 -> 32'h00004501 @0x300, then 32'h00A00513 @0x302. inst_valid is 0 between the two pushes while only 16'h0513 is held.
- Misaligned start: push 32'h4585_ABCD with pc=0x402 -> only 16'h4585 is stored (count=1); inst_out=32'h00004585, inst_pc=0x402.
- Full/wrap with DEPTH_HW=8 and inst_ready=0: four aligned pushes -> count=8, fetch_ready=0. Then drain while pushing; a 32-bit instruction at rd_ptr=7 assembles correctly across the wrap.
- Flush asserted together with fetch_valid and inst_ready while count=6 -> next cycle count=0 and inst_valid=0; the concurrent push is dropped. Async reset low mid-stream -> outputs are 0 immediately.
